rom_burst_loader: RTL

ROM_BURST_LOADER -- requirements
Module: rom_burst_loader

---
 rtl/rom_loader_pkg.sv | 19 +
 rtl/rom_burst_loader_if.sv | 66 ++++++
 rtl/rom_burst_loader_fifo.sv | 54 +++++
 rtl/rom_burst_loader.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/rom_loader_pkg.sv
// Shared constants for the ROM burst loader: default widths
// and the loader FSM state encodings.
package rom_loader_pkg;

    localparam int DEF_DATA_WIDTH    = 16;
    localparam int DEF_ADDRESS_WIDTH = 16;
    localparam int DEF_FIFO_DEPTH    = 4;

    typedef logic [2:0] state_t;

    localparam logic [2:0] ST_IDLE       = 3'd0;
    localparam logic [2:0] ST_WAIT_INIT  = 3'd1;
    localparam logic [2:0] ST_WRITE_REQ  = 3'd2;
    localparam logic [2:0] ST_WRITE_WAIT = 3'd3;
    localparam logic [2:0] ST_READ_REQ   = 3'd4;
    localparam logic [2:0] ST_READ_WAIT  = 3'd5;
    localparam logic [2:0] ST_DONE       = 3'd6;

endpackage

// File: rtl/rom_burst_loader_if.sv
// Loader-side and memory-encoder-side signals of rom_burst_loader.
// master: the loader core (drives ack, mem_*, status outputs).
// slave : the environment (external loader + memory encoder).
interface rom_burst_loader_if
    import rom_loader_pkg::*;
#(
    parameter int DATA_WIDTH    = DEF_DATA_WIDTH,
    parameter int ADDRESS_WIDTH = DEF_ADDRESS_WIDTH
);

    logic                     load;
    logic                     sck;
    logic [DATA_WIDTH-1:0]    input_data;
    logic                     ack;
    logic                     verify;
    logic                     mem_busy;
    logic                     mem_initialized;
    logic                     mem_request;
    logic                     mem_write_enable;
    logic [ADDRESS_WIDTH-1:0] mem_address;
    logic [DATA_WIDTH-1:0]    mem_write_data;
    logic [DATA_WIDTH-1:0]    mem_read_data;
    logic                     done;
    logic                     error;
    logic [ADDRESS_WIDTH-1:0] error_address;
    logic [ADDRESS_WIDTH:0]   word_count;

    modport master (
        input  load,
        input  sck,
        input  input_data,
        input  verify,
        input  mem_busy,
        input  mem_initialized,
        input  mem_read_data,
        output ack,
        output mem_request,
        output mem_write_enable,
        output mem_address,
        output mem_write_data,
        output done,
        output error,
        output error_address,
        output word_count
    );

    modport slave (
        output load,
        output sck,
        output input_data,
        output verify,
        output mem_busy,
        output mem_initialized,
        output mem_read_data,
        input  ack,
        input  mem_request,
        input  mem_write_enable,
        input  mem_address,
        input  mem_write_data,
        input  done,
        input  error,
        input  error_address,
        input  word_count
    );

endinterface

// File: rtl/rom_burst_loader_fifo.sv
// sync_fifo: single-clock FIFO between loader strobes and memory writes.
// Ports: push/i_data write side, pop/o_data read side, full/empty flags.
module sync_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             pop,
    output logic [WIDTH-1:0] o_data,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic             w_push_ok;
    logic             w_pop_ok;

    // Extra pointer bit tells full apart from empty.
    assign empty = (r_wr_ptr == r_rd_ptr);
    assign full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                   (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);

    assign w_push_ok = push && !full;
    assign w_pop_ok  = pop && !empty;
    assign o_data    = r_mem[r_rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
            end
            if (w_pop_ok) begin
                r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr[AW-1:0]] <= i_data;
        end
    end

endmodule

// File: rtl/rom_burst_loader.sv
// Buffers words strobed in by an external loader and writes them to
// memory, optionally reading each back to check it.
// Ports: clk, reset_n (async, active low), bus (master modport).
module rom_burst_loader
    import rom_loader_pkg::*;
#(
    parameter int DATA_WIDTH    = DEF_DATA_WIDTH,
    parameter int ADDRESS_WIDTH = DEF_ADDRESS_WIDTH,
    parameter int FIFO_DEPTH    = DEF_FIFO_DEPTH,
    parameter int VERIFY_EN     = 1
) (
    input  logic              clk,
    input  logic              reset_n,
    rom_burst_loader_if.master bus
);

    localparam logic [ADDRESS_WIDTH:0] WC_MAX =
        {1'b1, {ADDRESS_WIDTH{1'b0}}};

    state_t                   r_state;
    logic                     r_load_s1;
    logic                     r_load_s2;
    logic                     r_load_s3;
    logic                     r_sck_s1;
    logic                     r_sck_s2;
    logic                     r_sck_s3;
    logic [ADDRESS_WIDTH-1:0] r_addr;
    logic [ADDRESS_WIDTH:0]   r_wc;
    logic [DATA_WIDTH-1:0]    r_wdata;
    logic                     r_we;
    logic                     r_verify;
    logic                     r_done;
    logic                     r_error;
    logic [ADDRESS_WIDTH-1:0] r_err_addr;
    logic                     r_busy_d;

    logic                     w_load_rise;
    logic                     w_sck_rise;
    logic                     w_active;
    logic                     w_issue;
    logic                     w_req_state;
    logic                     w_req;
    logic                     w_push;
    logic                     w_pop;
    logic                     w_busy_fall;
    logic                     w_full;
    logic                     w_empty;
    logic [DATA_WIDTH-1:0]    w_head;

    assign w_load_rise = r_load_s2 && !r_load_s3;
    assign w_sck_rise  = r_sck_s2 && !r_sck_s3;

    assign w_active = (r_state != ST_IDLE) && (r_state != ST_DONE);

    // A request is only ever issued to an idle, initialised encoder;
    // otherwise the request state simply holds.
    assign w_issue     = bus.mem_initialized && !bus.mem_busy;
    assign w_req_state = (r_state == ST_WRITE_REQ) ||
                         (r_state == ST_READ_REQ);
    assign w_req       = w_req_state && w_issue;
    assign w_pop       = (r_state == ST_WRITE_REQ) && w_issue;
    assign w_push      = w_active && r_load_s2 && w_sck_rise;

    // Read data is valid in the cycle busy drops.
    assign w_busy_fall = r_busy_d && !bus.mem_busy;

    assign bus.ack              = w_active && !w_full;
    assign bus.mem_request      = w_req;
    assign bus.mem_write_enable = r_we;
    assign bus.mem_address      = r_addr;
    assign bus.mem_write_data   = r_wdata;
    assign bus.done             = r_done;
    assign bus.error            = r_error;
    assign bus.error_address    = r_err_addr;
    assign bus.word_count       = r_wc;

    sync_fifo #(
        .WIDTH (DATA_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (w_push),
        .i_data  (bus.input_data),
        .pop     (w_pop),
        .o_data  (w_head),
        .full    (w_full),
        .empty   (w_empty)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_load_s1 <= 1'b0;
            r_load_s2 <= 1'b0;
            r_load_s3 <= 1'b0;
            r_sck_s1  <= 1'b0;
            r_sck_s2  <= 1'b0;
            r_sck_s3  <= 1'b0;
            r_busy_d  <= 1'b0;
        end else begin
            r_load_s1 <= bus.load;
            r_load_s2 <= r_load_s1;
            r_load_s3 <= r_load_s2;
            r_sck_s1  <= bus.sck;
            r_sck_s2  <= r_sck_s1;
            r_sck_s3  <= r_sck_s2;
            r_busy_d  <= bus.mem_busy;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= ST_IDLE;
            r_addr     <= '0;
            r_wc       <= '0;
            r_wdata    <= '0;
            r_we       <= 1'b0;
            r_verify   <= 1'b0;
            r_done     <= 1'b0;
            r_error    <= 1'b0;
            r_err_addr <= '0;
        end else begin
            unique case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (w_load_rise) begin
                        r_state    <= ST_WAIT_INIT;
                        r_addr     <= '0;
                        r_wc       <= '0;
                        r_done     <= 1'b0;
                        r_error    <= 1'b0;
                        r_err_addr <= '0;
                        r_verify   <= (VERIFY_EN != 0) && bus.verify;
                    end
                end
                ST_WAIT_INIT: begin
                    if (!w_empty && w_issue) begin
                        r_wdata <= w_head;
                        r_we    <= 1'b1;
                        r_state <= ST_WRITE_REQ;
                    end else if (!r_load_s2 && w_empty) begin
                        r_done  <= 1'b1;
                        r_state <= ST_DONE;
                    end
                end
                ST_WRITE_REQ: begin
                    if (w_issue) begin
                        r_state <= ST_WRITE_WAIT;
                    end
                end
                ST_WRITE_WAIT: begin
                    if (w_busy_fall) begin
                        if (r_wc != WC_MAX) begin
                            r_wc <= r_wc + (ADDRESS_WIDTH+1)'(1);
                        end
                        if (r_verify) begin
                            r_we    <= 1'b0;
                            r_state <= ST_READ_REQ;
                        end else begin
                            r_addr  <= r_addr + ADDRESS_WIDTH'(1);
                            r_state <= ST_WAIT_INIT;
                        end
                    end
                end
                ST_READ_REQ: begin
                    if (w_issue) begin
                        r_state <= ST_READ_WAIT;
                    end
                end
                ST_READ_WAIT: begin
                    if (w_busy_fall) begin
                        // Only the first mismatch is recorded.
                        if (bus.mem_read_data != r_wdata) begin
                            r_error <= 1'b1;
                            if (!r_error) begin
                                r_err_addr <= r_addr;
                            end
                        end
                        r_addr  <= r_addr + ADDRESS_WIDTH'(1);
                        r_state <= ST_WAIT_INIT;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
